// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-port shared-ALU arbiter.
//   DATA_W   : operand/result width (only 32 is supported)
//   opcode_t : 3-bit ALU opcode, OP_NOT .. OP_ADD
//   state_e  : arbiter FSM state encoding
package alu_share_pkg;

    localparam int DATA_W = 32;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOT  = 3'b000;
    localparam opcode_t OP_AND  = 3'b001;
    localparam opcode_t OP_OR   = 3'b010;
    localparam opcode_t OP_XOR  = 3'b011;
    localparam opcode_t OP_XNOR = 3'b100;
    localparam opcode_t OP_LT   = 3'b101;
    localparam opcode_t OP_GT   = 3'b110;
    localparam opcode_t OP_ADD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu32_core.sv
// Purely combinational 32-bit ALU shared by the arbiter.
//   op : opcode (see alu_share_pkg)
//   a  : operand a
//   b  : operand b
//   y  : result; LT/GT give 32'h1 or 32'h0, ADD drops the carry
module alu32_core
    import alu_share_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] not_y;
    logic [DATA_W-1:0] and_y;
    logic [DATA_W-1:0] or_y;
    logic [DATA_W-1:0] xor_y;
    logic [DATA_W-1:0] xnor_y;
    logic [DATA_W-1:0] sum_y;
    logic              lt;
    logic              gt;

    gates32 u_gates (
        .a      (a),
        .b      (b),
        .not_y  (not_y),
        .and_y  (and_y),
        .or_y   (or_y),
        .xor_y  (xor_y),
        .xnor_y (xnor_y)
    );

    ult32 u_lt (
        .a  (a),
        .b  (b),
        .lt (lt)
    );

    // a > b is the same as b < a.
    ult32 u_gt (
        .a  (b),
        .b  (a),
        .lt (gt)
    );

    cla32 u_add (
        .a   (a),
        .b   (b),
        .sum (sum_y)
    );

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = not_y;
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            OP_XNOR: y = xnor_y;
            OP_LT:   y = {{(DATA_W-1){1'b0}}, lt};
            OP_GT:   y = {{(DATA_W-1){1'b0}}, gt};
            default: y = sum_y;
        endcase
    end

endmodule

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder, carry-in 0, carry-out dropped.
// Eight 4-bit groups; inside a group every carry is formed directly from
// the group carry-in and the running generate/propagate terms.
//   a, b : addends
//   sum  : a + b mod 2^32
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic c_grp;
        logic c_bit;
        logic g_run;
        logic p_run;
        // NOTE: every variable of an always_comb gets a value before any
        // conditional or loop, so no path can leave one unassigned (latch).
        sum   = '0;
        c_grp = 1'b0;
        c_bit = 1'b0;
        g_run = 1'b0;
        p_run = 1'b1;
        for (int grp = 0; grp < 8; grp++) begin
            g_run = 1'b0;
            p_run = 1'b1;
            c_bit = c_grp;
            for (int k = 0; k < 4; k++) begin
                sum[4*grp+k] = p[4*grp+k] ^ c_bit;
                g_run = g[4*grp+k] | (p[4*grp+k] & g_run);
                p_run = p[4*grp+k] & p_run;
                c_bit = g_run | (p_run & c_grp);
            end
            c_grp = c_bit;
        end
    end

endmodule

// File: rtl/gates32.sv
// 32-bit bitwise gate bank: NOT a, AND, OR, XOR and XNOR of two words.
//   a, b    : input operands
//   not_y   : ~a
//   and_y   : a & b
//   or_y    : a | b
//   xor_y   : a ^ b
//   xnor_y  : ~(a ^ b)
module gates32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] not_y,
    output logic [31:0] and_y,
    output logic [31:0] or_y,
    output logic [31:0] xor_y,
    output logic [31:0] xnor_y
);

    assign not_y  = ~a;
    assign and_y  = a & b;
    assign or_y   = a | b;
    assign xor_y  = a ^ b;
    assign xnor_y = ~(a ^ b);

endmodule

// File: rtl/ult32.sv
// 32-bit unsigned less-than comparator. A greater-than is obtained by
// instantiating it with the operands swapped.
//   a, b : unsigned operands
//   lt   : 1 when a < b
module ult32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    assign lt = (a < b);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. IDLE samples the requests and latches the winner's op and
// operands, EXEC registers the ALU output, DONE pulses the winner's ack.
//   clk, reset_n      : clock, asynchronous active-low reset
//   req0/op0/a0/b0    : requester 0 request, opcode, operands
//   req1/op1/a1/b1    : requester 1 request, opcode, operands
//   ack0, ack1        : one-cycle result-valid pulses (never both high)
//   result            : registered result, held until the next completion
//   busy              : high in EXEC and DONE
module alu_share_arbiter
    import alu_share_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  opcode_t           op0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              req1,
    input  opcode_t           op1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    state_e            state;
    state_e            state_nxt;
    logic              grant_en;
    logic              grant_id;
    logic              last_grant;
    logic              id_q;
    opcode_t           op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_y;

    // Next state and grant decision. On a tie the requester that was not
    // served last wins; a lone request always wins.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        grant_id  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_en  = 1'b1;
                    grant_id  = (req0 && req1) ? ~last_grant : req1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registers are written with <= so every always_ff samples the
    // pre-edge values of the others, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured at the grant edge, so requester changes after
    // that cannot disturb the in-flight operation. last_grant resets to 1
    // so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_NOT;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_en) begin
            op_q       <= grant_id ? op1 : op0;
            a_q        <= grant_id ? a1 : a0;
            b_q        <= grant_id ? b1 : b0;
            id_q       <= grant_id;
            last_grant <= grant_id;
        end
    end

    alu32_core u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // The EXEC->DONE edge loads the result and raises the ack, so the ack
    // is high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (state == ST_EXEC) begin
                result <= alu_y;
                ack0   <= ~id_q;
                ack1   <= id_q;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. A schedule-level model predicts
// ack0/ack1/result/busy every cycle; directed tests add literal expectations.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [2:0]  op0 = 3'd0;
    logic [2:0]  op1 = 3'd0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        ack0;
    logic        ack1;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .op0     (op0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .op1     (op1),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .result  (result),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a ^ b);
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return (a > b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    // A grant at edge g completes (result + ack visible) after edge g+1,
    // keeps the block busy through the cycle after g+1, and the next grant
    // may happen at edge g+3 at the earliest.
    int          cyc = 0;
    int          free_at = 0;
    int          done_edge = -1;
    bit          done_id = 1'b0;
    logic [31:0] done_val = '0;
    bit          last_id = 1'b1;
    bit          win;
    bit          exp_ack0 = 1'b0;
    bit          exp_ack1 = 1'b0;
    bit          exp_busy = 1'b0;
    logic [31:0] exp_result = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_at    = 0;
            done_edge  = -1;
            last_id    = 1'b1;
            exp_ack0   = 1'b0;
            exp_ack1   = 1'b0;
            exp_busy   = 1'b0;
            exp_result = '0;
        end else begin
            cyc++;
            exp_ack0 = 1'b0;
            exp_ack1 = 1'b0;
            if (cyc == done_edge) begin
                exp_result = done_val;
                if (done_id) exp_ack1 = 1'b1;
                else         exp_ack0 = 1'b1;
            end
            if (cyc >= free_at && (req0 || req1)) begin
                win       = (req0 && req1) ? !last_id : req1;
                last_id   = win;
                done_id   = win;
                done_val  = win ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0);
                done_edge = cyc + 1;
                free_at   = cyc + 3;
            end
            exp_busy = (free_at - cyc) >= 2;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_ack0",   32'(ack0), 32'(exp_ack0));
            check("cyc_ack1",   32'(ack1), 32'(exp_ack1));
            check("cyc_result", result,    exp_result);
            check("cyc_busy",   32'(busy), 32'(exp_busy));
            if (ack0 && ack1) check("ack_exclusive", 32'd1, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input bit which, input int budget, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        repeat (budget) begin
            @(negedge clk);
            waited++;
            if ((which ? ack1 : ack0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(ok), 32'd1);
    endtask

    task automatic drive(input bit id, input bit req, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1 = req; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = req; op0 = op; a0 = a; b0 = b;
        end
    endtask

    task automatic single_op(input string name, input bit id, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        int w;
        @(negedge clk);
        drive(id, 1'b1, op, a, b);
        wait_ack(id, 8, w);
        check({name, "_latency"}, 32'(w), 32'd2);
        check({name, "_result"}, result, exp);
        check({name, "_other_ack"}, 32'(id ? ack0 : ack1), 32'd0);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        int w;
        int k;
        int gap;
        bit id;

        // Reset held with both requests pending.
        drive(0, 1'b1, 3'b001, 32'h0000FFFF, 32'h00FF00FF);
        drive(1, 1'b1, 3'b010, 32'h11111111, 32'h22222222);
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack0",   32'(ack0), 32'd0);
        check("rst_ack1",   32'(ack1), 32'd0);
        check("rst_result", result,    32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        #1 reset_n = 1'b1;
        wait_ack(0, 8, w);
        check("rst_first_latency", 32'(w), 32'd2);
        check("rst_first_result", result, 32'h000000FF);
        check("rst_first_not_req1", 32'(ack1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;

        // Single operations.
        single_op("and",     0, 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        single_op("not",     0, 3'b000, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0);
        single_op("lt_eq",   0, 3'b101, 32'd7,        32'd7,        32'd0);
        single_op("gt_uns",  1, 3'b110, 32'h80000000, 32'd1,        32'd1);
        single_op("xnor_eq", 1, 3'b100, 32'h12345678, 32'h12345678, 32'hFFFFFFFF);

        // Tie: last served was requester 1, so requester 0 goes first.
        @(negedge clk);
        drive(0, 1'b1, 3'b111, 32'hFFFFFFFF, 32'd1);
        drive(1, 1'b1, 3'b101, 32'd3, 32'd5);
        wait_ack(0, 8, w);
        check("tie_first_latency", 32'(w), 32'd2);
        check("tie_add_wrap", result, 32'd0);
        req0 = 1'b0;
        wait_ack(1, 8, w);
        check("tie_second_gap", 32'(w), 32'd3);
        check("tie_lt_result", result, 32'd1);
        req1 = 1'b0;

        // Continuous contention for 12 grants.
        @(negedge clk);
        drive(0, 1'b1, 3'b111, 32'd100, 32'd23);
        drive(1, 1'b1, 3'b010, 32'h000000F0, 32'h0000000F);
        k = 0;
        gap = 0;
        repeat (60) begin
            @(negedge clk);
            gap++;
            if (ack0 || ack1) begin
                id = ack1;
                check("cont_order", 32'(id), 32'(k % 2));
                if (k > 0) check("cont_gap", 32'(gap), 32'd3);
                check("cont_result", result, id ? 32'h000000FF : 32'd123);
                gap = 0;
                k++;
                if (k == 12) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                    break;
                end
            end
        end
        check("cont_grants", 32'(k), 32'd12);

        // Reset pulse while an operation is in EXEC.
        @(negedge clk);
        drive(0, 1'b1, 3'b011, 32'hAAAAAAAA, 32'h55555555);
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        check("exec_rst_result", result, 32'd0);
        check("exec_rst_busy", 32'(busy), 32'd0);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("exec_rst_no_ack", 32'(ack0 | ack1), 32'd0);
        end
        single_op("post_rst_not", 1, 3'b000, 32'd0, 32'd0, 32'hFFFFFFFF);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
